// File: rtl/acc_offload_tracker_pkg.sv
// Shared types for the accelerator offload tracker: request/response payloads,
// tracker FSM states and the outstanding-counter width helper.
package acc_pkg;

    localparam int unsigned IdWidth   = 1;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned InstrWidth = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ERROR = 2'd2
    } tracker_state_e;

    typedef struct packed {
        logic [DataWidth-1:0]  data_arga;
        logic [InstrWidth-1:0] instr;
        logic [IdWidth-1:0]    id;
    } acc_c_q_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
        logic [IdWidth-1:0]   id;
    } acc_c_p_t;

    typedef struct packed {
        acc_c_q_t q;
        logic     q_valid;
        logic     p_ready;
    } acc_c_req_t;

    typedef struct packed {
        acc_c_p_t p;
        logic     p_valid;
        logic     q_ready;
    } acc_c_rsp_t;

    // Bits needed to count 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/acc_offload_tracker_if.sv
// Offload request/response channel between core adapter, tracker and interconnect.
interface acc_offload_tracker_if;
    import acc_pkg::*;

    acc_c_req_t req;
    acc_c_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);

endinterface

// File: rtl/acc_offload_tracker_fifo.sv
// Timestamp FIFO (fifo_v3-compatible naming); the owner guarantees no overflow or
// underflow, and a push into a full FIFO is only legal together with a pop.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;

    assign data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrWidth'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrWidth'(1);
            end
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/acc_offload_tracker.sv
// In-flight tracker for one accelerator requester port: credit limit, ordered drain,
// latency capture. Optional watchdog enabled by ACC_OFFLOAD_TRACKER_TIMEOUT_EN.
module acc_offload_tracker
    import acc_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TsWidth        = 16,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    acc_offload_tracker_if.slave                 acc_c_slv,
    acc_offload_tracker_if.master                acc_c_mst,
    input  logic                                 drain_i,
    output logic                                 drained_o,
    output logic [cnt_width(MaxOutstanding)-1:0] outstanding_o,
    output logic [TsWidth-1:0]                   max_latency_o,
    output logic                                 unexp_rsp_o,
    output logic                                 timeout_o
);
    localparam int unsigned CntWidth = cnt_width(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    if (MaxOutstanding == 0 || 64'(TimeoutCycles) >= (64'd1 << TsWidth)) begin : g_bad_cfg
        $error("acc_offload_tracker: MaxOutstanding must be >= 1 and TimeoutCycles < 2**TsWidth");
    end

    tracker_state_e      state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [TsWidth-1:0]  now_q, head_ts, lat, max_latency_q;
    logic                unexp_q;
    logic                p_hs, push, pop, allow, wd_fire;

    // Handshakes and credit check; a same-cycle pop frees its slot for the push.
    assign p_hs    = acc_c_mst.rsp.p_valid & acc_c_slv.req.p_ready;
    assign pop     = p_hs & (count_q != '0);
    assign allow   = (state_q == RUN) && ((count_q - CntWidth'(pop)) < CntMax);
    assign push    = acc_c_slv.req.q_valid & acc_c_mst.rsp.q_ready & allow;
    assign lat     = now_q - head_ts;
    assign count_d = count_q + CntWidth'(push) - CntWidth'(pop);

    assign acc_c_mst.req = '{q:       acc_c_slv.req.q,
                             q_valid: acc_c_slv.req.q_valid & allow,
                             p_ready: acc_c_slv.req.p_ready};
    assign acc_c_slv.rsp = '{p:       acc_c_mst.rsp.p,
                             p_valid: acc_c_mst.rsp.p_valid,
                             q_ready: acc_c_mst.rsp.q_ready & allow};

    fifo_v3 #(
        .DATA_WIDTH (TsWidth),
        .DEPTH      (MaxOutstanding)
    ) i_ts_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .data_i  (now_q),
        .push_i  (push),
        .data_o  (head_ts),
        .pop_i   (pop)
    );

`ifdef ACC_OFFLOAD_TRACKER_TIMEOUT_EN
    localparam logic [TsWidth-1:0] WdLimit = TsWidth'(TimeoutCycles);
    logic timeout_q;

    // Oldest outstanding request has waited too long.
    assign wd_fire = (count_q != '0) && (lat >= WdLimit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_i)  state_d = DRAIN;
            DRAIN:   if (!drain_i) state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
        if (wd_fire) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q       <= '0;
            now_q         <= '0;
            max_latency_q <= '0;
            unexp_q       <= 1'b0;
        end else begin
            count_q <= count_d;
            now_q   <= now_q + TsWidth'(1);
            if (pop && (lat > max_latency_q)) begin
                max_latency_q <= lat;
            end
            if (p_hs && (count_q == '0)) begin
                unexp_q <= 1'b1;
            end
        end
    end

    assign drained_o     = (state_q == DRAIN) && (count_q == '0);
    assign outstanding_o = count_q;
    assign max_latency_o = max_latency_q;
    assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_acc_offload_tracker.sv
// Directed bench for acc_offload_tracker with request/response scoreboards.
module tb_acc_offload_tracker;
    import acc_pkg::*;

`ifdef ACC_OFFLOAD_TRACKER_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic clk;
    logic rst, rst_w;
    logic drain;
    logic drained, unexp, timeout;
    logic [2:0]  outstanding;
    logic [15:0] max_lat;
    logic drained_w, unexp_w, timeout_w;
    logic [2:0]  outstanding_w;
    logic [3:0]  max_lat_w;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_p[$];
    int exp_b2b[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

    acc_offload_tracker_if slv_if ();
    acc_offload_tracker_if mst_if ();
    acc_offload_tracker_if slv_w_if ();
    acc_offload_tracker_if mst_w_if ();

    acc_offload_tracker #(
        .MaxOutstanding (4),
        .TsWidth        (16),
        .TimeoutCycles  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .acc_c_slv     (slv_if),
        .acc_c_mst     (mst_if),
        .drain_i       (drain),
        .drained_o     (drained),
        .outstanding_o (outstanding),
        .max_latency_o (max_lat),
        .unexp_rsp_o   (unexp),
        .timeout_o     (timeout)
    );

    acc_offload_tracker #(
        .MaxOutstanding (4),
        .TsWidth        (4),
        .TimeoutCycles  (12)
    ) dut_w (
        .clk_i         (clk),
        .rst_i         (rst_w),
        .acc_c_slv     (slv_w_if),
        .acc_c_mst     (mst_w_if),
        .drain_i       (1'b0),
        .drained_o     (drained_w),
        .outstanding_o (outstanding_w),
        .max_latency_o (max_lat_w),
        .unexp_rsp_o   (unexp_w),
        .timeout_o     (timeout_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops scoreboards on handshakes completing this cycle.
    task automatic settle();
        #2;
        chk("p_ready_thru", 32'(mst_if.req.p_ready), 32'(slv_if.req.p_ready));
        if (mst_if.req.q_valid && mst_if.rsp.q_ready) begin
            chk("q_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("q_instr", mst_if.req.q.instr, e);
                chk("q_arga", mst_if.req.q.data_arga, 32'hC0DE_0000 | e);
            end
        end
        if (slv_if.rsp.p_valid && slv_if.req.p_ready) begin
            chk("p_sb_nonempty", 32'(exp_p.size() != 0), 32'd1);
            if (exp_p.size() != 0) begin
                chk("p_data", slv_if.rsp.p.data, exp_p.pop_front());
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            settle();
        end
    endtask

    task automatic send_req(input int tag, input bit sb);
        slv_if.req.q_valid     = 1'b1;
        slv_if.req.q.instr     = 32'(tag);
        slv_if.req.q.data_arga = 32'hC0DE_0000 | 32'(tag);
        slv_if.req.q.id        = 1'b0;
        if (sb) exp_q.push_back(32'(tag));
    endtask

    task automatic clr_req();
        slv_if.req.q_valid = 1'b0;
    endtask

    task automatic send_rsp(input int tag);
        mst_if.rsp.p_valid = 1'b1;
        mst_if.rsp.p.data  = 32'(tag);
        mst_if.rsp.p.error = 1'b0;
        mst_if.rsp.p.id    = 1'b0;
        exp_p.push_back(32'(tag));
    endtask

    task automatic clr_rsp();
        mst_if.rsp.p_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        drain = 1'b0;
        slv_if.req = '0;
        mst_if.rsp = '0;
        slv_w_if.req = '0;
        mst_w_if.rsp = '0;
        slv_if.req.p_ready = 1'b1;
        mst_if.rsp.q_ready = 1'b1;
        slv_w_if.req.p_ready = 1'b1;
        mst_w_if.rsp.q_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_maxlat", 32'(max_lat), 0);
        chk("rst_unexp", 32'(unexp), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_drained", 32'(drained), 0);

        // Back-to-back: 4 requests, each answered 3 cycles later
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 4) send_req(100 + i, 1'b1); else clr_req();
            if (i >= 3 && i < 7) send_rsp(200 + i - 3); else clr_rsp();
            settle();
            chk($sformatf("b2b_out%0d", i), 32'(outstanding), 32'(exp_b2b[i]));
            if (i < 4) chk("b2b_no_stall", 32'(slv_if.rsp.q_ready), 1);
        end
        idle(1);
        chk("b2b_maxlat", 32'(max_lat), 3);

        // Credit stall: fifth request waits for the first response
        for (int i = 0; i < 4; i++) begin
            tick();
            send_req(10 + i, 1'b1);
            settle();
            chk("credit_fill_ready", 32'(slv_if.rsp.q_ready), 1);
        end
        tick();
        send_req(14, 1'b1);
        settle();
        chk("stall_out", 32'(outstanding), 4);
        chk("stall_mst_qvalid", 32'(mst_if.req.q_valid), 0);
        chk("stall_slv_qready", 32'(slv_if.rsp.q_ready), 0);
        idle(1);
        chk("stall_hold", 32'(mst_if.req.q_valid), 0);
        tick();
        send_rsp(50);
        settle();
        chk("credit_mst_qvalid", 32'(mst_if.req.q_valid), 1);
        chk("credit_slv_qready", 32'(slv_if.rsp.q_ready), 1);
        for (int i = 1; i < 5; i++) begin
            tick();
            clr_req();
            send_rsp(50 + i);
            settle();
            if (i == 1) chk("credit_out_same", 32'(outstanding), 4);
        end
        tick();
        clr_rsp();
        settle();
        chk("credit_out_end", 32'(outstanding), 0);
        chk("credit_maxlat", 32'(max_lat), 6);

        // Drain with two requests in flight
        tick(); send_req(20, 1'b1); settle();
        tick(); send_req(21, 1'b1); settle();
        tick(); clr_req(); drain = 1'b1; settle();
        chk("drain_out2", 32'(outstanding), 2);
        tick(); send_req(22, 1'b1); settle();
        chk("drain_block", 32'(mst_if.req.q_valid), 0);
        chk("drain_slv_qready", 32'(slv_if.rsp.q_ready), 0);
        chk("drain_not_done", 32'(drained), 0);
        tick(); send_rsp(60); settle();
        tick(); send_rsp(61); settle();
        chk("drained_pre", 32'(drained), 0);
        tick(); clr_rsp(); settle();
        chk("drained_rise", 32'(drained), 1);
        chk("drain_still_block", 32'(mst_if.req.q_valid), 0);
        tick(); drain = 1'b0; settle();
        idle(1);
        chk("drain_fwd", 32'(mst_if.req.q_valid), 1);
        chk("drain_fwd_ready", 32'(slv_if.rsp.q_ready), 1);
        tick(); clr_req(); send_rsp(62); settle();
        chk("drain_out1", 32'(outstanding), 1);
        tick(); clr_rsp(); settle();
        chk("drain_out0", 32'(outstanding), 0);

        // Unexpected response with nothing in flight
        tick(); send_rsp(16'h55); settle();
        chk("unexp_pre", 32'(unexp), 0);
        chk("unexp_passed", 32'(slv_if.rsp.p_valid), 1);
        tick(); clr_rsp(); settle();
        chk("unexp_set", 32'(unexp), 1);
        chk("unexp_out", 32'(outstanding), 0);
        tick();
        slv_if.req.p_ready = 1'b0;
        mst_if.rsp.p_valid = 1'b1;
        mst_if.rsp.p.data  = 32'h66;
        settle();
        chk("p_valid_thru", 32'(slv_if.rsp.p_valid), 1);
        chk("p_data_thru", slv_if.rsp.p.data, 32'h66);
        tick();
        mst_if.rsp.p_valid = 1'b0;
        slv_if.req.p_ready = 1'b1;
        settle();
        idle(2);
        chk("unexp_sticky", 32'(unexp), 1);
        chk("unexp_out_still0", 32'(outstanding), 0);

        // Watchdog: one request left unanswered
        do_reset();
        chk("rst2_unexp", 32'(unexp), 0);
        chk("rst2_maxlat", 32'(max_lat), 0);
        tick(); send_req(30, 1'b1); settle();
        tick(); clr_req(); settle();
        idle(15);
        chk("tmo_pre", 32'(timeout), 0);
        tick(); send_req(31, !ToEn); settle();
        chk("tmo_set", 32'(timeout), 32'(ToEn));
        chk("tmo_block", 32'(slv_if.rsp.q_ready), 32'(!ToEn));
        tick(); clr_req(); send_rsp(70); settle();
        tick();
        if (!ToEn) send_rsp(71); else clr_rsp();
        settle();
        tick(); clr_rsp(); settle();
        chk("tmo_out", 32'(outstanding), 0);
        chk("tmo_sticky", 32'(timeout), 32'(ToEn));
        chk("tmo_maxlat", 32'(max_lat), 18);
        do_reset();
        chk("rst3_timeout", 32'(timeout), 0);
        chk("rst3_out", 32'(outstanding), 0);
        tick(); send_req(32, 1'b1); settle();
        chk("rst3_accept", 32'(slv_if.rsp.q_ready), 1);
        tick(); clr_req(); send_rsp(72); settle();
        tick(); clr_rsp(); settle();
        chk("rst3_out_end", 32'(outstanding), 0);

        // Timestamp wrap on the 4-bit instance: latency 5 across now=15->0
        tick(); rst_w = 1'b1;
        tick(); rst_w = 1'b0; settle();
        idle(12);
        tick();
        slv_w_if.req.q_valid = 1'b1;
        slv_w_if.req.q.instr = 32'h13;
        settle();
        chk("wrap_fwd", 32'(mst_w_if.req.q_valid), 1);
        tick(); slv_w_if.req.q_valid = 1'b0; settle();
        idle(3);
        tick();
        mst_w_if.rsp.p_valid = 1'b1;
        settle();
        chk("wrap_maxlat_pre", 32'(max_lat_w), 0);
        chk("wrap_p_valid", 32'(slv_w_if.rsp.p_valid), 1);
        tick(); mst_w_if.rsp.p_valid = 1'b0; settle();
        chk("wrap_maxlat", 32'(max_lat_w), 5);
        tick(); slv_w_if.req.q_valid = 1'b1; settle();
        tick(); slv_w_if.req.q_valid = 1'b0; settle();
        tick(); mst_w_if.rsp.p_valid = 1'b1; settle();
        tick(); mst_w_if.rsp.p_valid = 1'b0; settle();
        chk("wrap_maxlat_keep", 32'(max_lat_w), 5);
        chk("wrap_out", 32'(outstanding_w), 0);
        chk("wrap_unexp", 32'(unexp_w), 0);
        chk("wrap_timeout", 32'(timeout_w), 0);
        chk("wrap_drained", 32'(drained_w), 0);

        chk("sb_q_empty", 32'(exp_q.size()), 0);
        chk("sb_p_empty", 32'(exp_p.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
